// File: rtl/mcbsp_pkg.sv
// Shared types, limits and config-decoding helpers for the McBSP receive path.
package mcbsp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } mcbsp_state_e;

    localparam int MCBSP_MAX_LEN   = 32;
    localparam int MCBSP_MAX_WORDS = 512;

    // Word length register to effective bit count: 0 or anything above 32 means 32.
    function automatic logic [5:0] eff_len(input logic [6:0] len7);
        logic [5:0] w_len;
        if ((len7 == 7'd0) || (len7 > 7'd32)) begin
            w_len = 6'(MCBSP_MAX_LEN);
        end else begin
            w_len = len7[5:0];
        end
        return w_len;
    endfunction

    // Words-per-frame register to effective count: 0 means 512.
    function automatic logic [9:0] eff_num(input logic [8:0] num9);
        logic [9:0] w_num;
        if (num9 == 9'd0) begin
            w_num = 10'(MCBSP_MAX_WORDS);
        end else begin
            w_num = {1'b0, num9};
        end
        return w_num;
    endfunction

endpackage

// File: rtl/mcbsp_rx_shifter.sv
// Serial-to-parallel shifter: MSB-first shift register, bit counter, and the
// right-aligned word as it will look once the bit on the line is shifted in.
module mcbsp_rx_shifter
    import mcbsp_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic              i_mosi,
    input  logic [5:0]        i_len,
    output logic [5:0]        o_bit_cnt,
    output logic [MCBSP_MAX_LEN-1:0] o_shreg,
    output logic              o_last,
    output logic [DATA_W-1:0] o_word
);

    logic [5:0]               r_bit_cnt;
    logic [MCBSP_MAX_LEN-1:0] r_shreg;
    logic [MCBSP_MAX_LEN-1:0] w_next_shreg;
    logic [MCBSP_MAX_LEN-1:0] w_mask;

    // The completing bit is folded in combinationally so the write lands on the last-bit edge.
    assign w_next_shreg = {r_shreg[MCBSP_MAX_LEN-2:0], i_mosi};
    // A shift by 32 yields zero, so the mask becomes all ones for full-width words.
    assign w_mask       = (32'd1 << i_len) - 32'd1;
    assign o_last       = (r_bit_cnt == (i_len - 6'd1));
    assign o_word       = DATA_W'(w_next_shreg & w_mask);
    assign o_bit_cnt    = r_bit_cnt;
    assign o_shreg      = r_shreg;

    // Shift register and bit counter: clear on frame sync, shift one bit per edge in SHIFT.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_bit_cnt <= 6'd0;
            r_shreg   <= '0;
        end else if (i_clear) begin
            r_bit_cnt <= 6'd0;
            r_shreg   <= '0;
        end else if (i_shift) begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
            r_shreg   <= w_next_shreg;
        end else begin
            r_bit_cnt <= r_bit_cnt;
            r_shreg   <= r_shreg;
        end
    end

endmodule

// File: rtl/mcbsp_slave_rx.sv
// McBSP slave receiver: frame-sync driven FSM, word/frame counters and the
// RAM write port. Bit-level deserialisation lives in mcbsp_rx_shifter.
module mcbsp_slave_rx
    import mcbsp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int FCNT_W = 16
)
(
    input  logic              mcbsp_clk_in,
    input  logic              mcbsp_rst_in,
    input  logic [8:0]        mcbsp_reg_number,
    input  logic [6:0]        mcbsp_reg_length,
    input  logic              mcbsp_slave_en,
    input  logic              mcbsp_slave_fsx,
    input  logic              mcbsp_slave_mosi,
    output logic              mcbsp_wr_en,
    output logic [ADDR_W-1:0] mcbsp_wr_addr,
    output logic [DATA_W-1:0] mcbsp_wr_data,
    output logic              mcbsp_frame_done,
    output logic              mcbsp_sync_err,
    output logic              mcbsp_busy,
    output logic [FCNT_W-1:0] mcbsp_frame_cnt,
    output logic [63:0]       debug_signal
);

    localparam int DBG_PAD = 64 - (1 + 6 + ADDR_W + MCBSP_MAX_LEN + 2);

    mcbsp_state_e              r_state, w_state_nxt;
    logic [ADDR_W-1:0]         r_word_cnt, w_word_cnt_nxt;
    logic [ADDR_W-1:0]         r_num_m1, w_num_m1_nxt;
    logic [5:0]                r_len, w_len_nxt;
    logic                      r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0]         r_wr_addr, w_wr_addr_nxt;
    logic [DATA_W-1:0]         r_wr_data, w_wr_data_nxt;
    logic                      r_frame_done, w_frame_done_nxt;
    logic                      r_sync_err, w_sync_err_nxt;
    logic                      r_busy;
    logic [FCNT_W-1:0]         r_frame_cnt, w_frame_cnt_nxt;
    logic [63:0]               r_debug, w_debug;
    logic                      w_clear, w_shift, w_last;
    logic [5:0]                w_bit_cnt;
    logic [MCBSP_MAX_LEN-1:0]  w_shreg;
    logic [DATA_W-1:0]         w_word;
    logic [5:0]                w_eff_len;
    logic [ADDR_W-1:0]         w_eff_num_m1;

    assign w_eff_len    = eff_len(mcbsp_reg_length);
    assign w_eff_num_m1 = ADDR_W'(eff_num(mcbsp_reg_number) - 10'd1);

    mcbsp_rx_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk_in    (mcbsp_clk_in),
        .rst_in    (mcbsp_rst_in),
        .i_clear   (w_clear),
        .i_shift   (w_shift),
        .i_mosi    (mcbsp_slave_mosi),
        .i_len     (r_len),
        .o_bit_cnt (w_bit_cnt),
        .o_shreg   (w_shreg),
        .o_last    (w_last),
        .o_word    (w_word)
    );

    // Next-state, counter and write-port decisions; strobes default low every cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_word_cnt_nxt   = r_word_cnt;
        w_num_m1_nxt     = r_num_m1;
        w_len_nxt        = r_len;
        w_wr_en_nxt      = 1'b0;
        w_wr_addr_nxt    = r_wr_addr;
        w_wr_data_nxt    = r_wr_data;
        w_frame_done_nxt = 1'b0;
        w_sync_err_nxt   = 1'b0;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_clear          = 1'b0;
        w_shift          = 1'b0;
        case (r_state)
            IDLE: begin
                if (mcbsp_slave_en && mcbsp_slave_fsx) begin
                    w_state_nxt  = SHIFT;
                    w_len_nxt    = w_eff_len;
                    w_num_m1_nxt = w_eff_num_m1;
                    w_clear      = 1'b1;
                end else if (!mcbsp_slave_en) begin
                    w_word_cnt_nxt = '0;
                end else begin
                    w_word_cnt_nxt = r_word_cnt;
                end
            end
            SHIFT: begin
                if (mcbsp_slave_fsx) begin
                    // Early frame sync: drop the partial word and start over as a fresh FS.
                    w_sync_err_nxt = 1'b1;
                    w_len_nxt      = w_eff_len;
                    w_num_m1_nxt   = w_eff_num_m1;
                    w_clear        = 1'b1;
                end else begin
                    w_shift = 1'b1;
                    if (w_last) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_word_cnt;
                        w_wr_data_nxt = w_word;
                        w_state_nxt   = IDLE;
                        if (r_word_cnt == r_num_m1) begin
                            w_frame_done_nxt = 1'b1;
                            w_word_cnt_nxt   = '0;
                            w_frame_cnt_nxt  = r_frame_cnt + FCNT_W'(1'b1);
                        end else begin
                            w_word_cnt_nxt = r_word_cnt + ADDR_W'(1'b1);
                        end
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Debug probe snapshot: state, bit_cnt, word_cnt, shift register, fsx, mosi.
    always_comb begin
        w_debug = {{DBG_PAD{1'b0}}, mcbsp_slave_mosi, mcbsp_slave_fsx, w_shreg,
                   r_word_cnt, w_bit_cnt, (r_state == SHIFT)};
    end

    // State, configuration latches, counters and all registered outputs.
    always_ff @(posedge mcbsp_clk_in or posedge mcbsp_rst_in) begin
        if (mcbsp_rst_in) begin
            r_state      <= IDLE;
            r_word_cnt   <= '0;
            r_num_m1     <= '0;
            r_len        <= 6'(MCBSP_MAX_LEN);
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_cnt  <= '0;
            r_debug      <= 64'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_num_m1     <= w_num_m1_nxt;
            r_len        <= w_len_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_sync_err   <= w_sync_err_nxt;
            r_busy       <= (w_state_nxt == SHIFT);
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_debug      <= w_debug;
        end
    end

    assign mcbsp_wr_en      = r_wr_en;
    assign mcbsp_wr_addr    = r_wr_addr;
    assign mcbsp_wr_data    = r_wr_data;
    assign mcbsp_frame_done = r_frame_done;
    assign mcbsp_sync_err   = r_sync_err;
    assign mcbsp_busy       = r_busy;
    assign mcbsp_frame_cnt  = r_frame_cnt;
    assign debug_signal     = r_debug;

endmodule

// File: doc/mcbsp_slave_rx.md
Name: mcbsp_slave_rx

Overview:
- Receive-side McBSP deserializer for the Link16 DSP interface.
- Accepts the DSP's serial stream (bit clock, per-word frame sync, data) and rebuilds words MSB-first.
- Writes each completed word into a dual-port TX RAM through a simple write port, and flags frame completion and sync errors to the slot controller.
- Counterpart of the McBSP master transmitter: same frame format (1-cycle FS pulse, 1-bit data delay, configurable word length and words per frame).

Parameters:
- DATA_W, 32, maximum word width and width of the write-data bus.
- ADDR_W, 9, RAM address width; also the width of the word counter.
- FCNT_W, 16, width of the free-running completed-frame counter.

Ports:
- mcbsp_clk_in  input  1  serial bit clock (20 MHz); all logic on rising edge (the far end drives on falling edge).
- mcbsp_rst_in  input  1  reset, asynchronous, active-high.
- mcbsp_reg_number  input  9  words per frame; 0 means 512.
- mcbsp_reg_length  input  7  bits per word; 0 or >32 means 32.
- mcbsp_slave_en  input  1  receive enable.
- mcbsp_slave_fsx  input  1  frame sync, 1-cycle high pulse per word.
- mcbsp_slave_mosi  input  1  serial data, MSB first.
- mcbsp_wr_en  output  1  1-cycle write strobe.
- mcbsp_wr_addr  output  ADDR_W  word index within the frame.
- mcbsp_wr_data  output  DATA_W  received word, right-aligned, upper bits zero.
- mcbsp_frame_done  output  1  1-cycle pulse when the last word of a frame is written.
- mcbsp_sync_err  output  1  1-cycle pulse on FS during a word.
- mcbsp_busy  output  1  high while in SHIFT.
- mcbsp_frame_cnt  output  FCNT_W  completed frames; wraps.
- debug_signal  output  64  probe bus: state, bit_cnt, word_cnt, shreg[31:0], fsx, mosi; unused bits 0.

Behaviour:
- Reset (async): state=IDLE; bit_cnt=0, word_cnt=0, shreg=0.
- Reset values of outputs: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, sync_err=0, busy=0, frame_cnt=0.
- Reset mid-word discards the partial word; nothing is written.
- Registered outputs: every output is registered. Strobes (wr_en, frame_done, sync_err) default to 0 each cycle.
- IDLE:
  - If en=1 and fsx=1 at an edge: latch effective length L (1..32) and effective number N (1..512); bit_cnt=0; go to SHIFT.
  - If en=0: word_cnt=0. This means disabling between words restarts the frame at address 0.
- SHIFT: at each edge, shreg <= {shreg[30:0], mosi} and bit_cnt++. The first data bit is sampled at the edge after the FS edge (1-bit data delay).
- Word complete, at the edge sampling bit L-1:
  - wr_en=1; wr_data = the L received bits right-aligned; wr_addr = word_cnt. Write occurs on the same edge as the last-bit sample.
  - word_cnt++, go to IDLE.
  - If word_cnt was N-1: frame_done=1, word_cnt=0, frame_cnt++.
- Back-to-back words: FS in the cycle right after the last bit is legal. IDLE accepts it, giving a zero-gap stream of L+1 cycles per word.
- FS while in SHIFT (any bit_cnt, including the last-bit cycle):
  - sync_err=1; the partial word is discarded with no write; word_cnt unchanged.
  - Restart SHIFT with bit_cnt=0 and re-latch L/N (treated as a new FS).
- en deasserted mid-word: the current word completes and is written. en only gates acceptance of FS in IDLE.
- Config changes take effect only at the next accepted FS. An N change mid-frame applies from the next word; if word_cnt >= new N, the frame ends at word 511 wrap. Software changes config only when frame_done or en=0.
- word_cnt wraps 511->0 naturally when N=512.
- frame_cnt wraps (0xFFFF+1 -> 0).

Decomposition:
- Shared package mcbsp_pkg:
  - state enum {IDLE, SHIFT};
  - constants MCBSP_MAX_LEN=32, MCBSP_MAX_WORDS=512;
  - function eff_len(len7) returning 1..32;
  - function eff_num(num9) returning 1..512.
- One natural sub-module, mcbsp_rx_shifter: shift register, bit counter, and word-complete/right-align logic. The top level holds the FSM, word/frame counters and the write port.

Test Plan:
- Single word: N=1, L=32, en=1, FS then 0xA5C3_0F81 MSB-first -> one wr_en with addr 0, data 0xA5C30F81, frame_done in the same cycle, frame_cnt=1.
- Short words, back-to-back: L=8, N=3, bytes 0x12, 0x34, 0x56 with zero gap -> wr_en at cycles 9, 18, 27 after the first FS; addr 0/1/2; data 0x00000012/34/56; one frame_done on the third write.
- Early FS: L=16, FS again after 5 bits -> sync_err pulse, no write, then 16 bits 0xBEEF -> write addr 0, data 0x0000BEEF.
- Length 0 / >32: L=0, then L=40, each sending 32 bits 0xFFFF_0001 -> both treated as 32; data 0xFFFF0001.
- N=0 wrap: L=4, 512 words -> frame_done only on addr 511, word_cnt back to 0, frame_cnt=1.
- Reset mid-word: assert rst after 10 of 32 bits -> all outputs 0 immediately, no write; the next full word writes addr 0. Also: en=0 in IDLE with FS -> ignored, no busy.
